// File: rtl/pid_error_gen.sv
// pid_error_gen: front end of the stimulation control loop.
//
// Feedback samples arrive on a valid/ready handshake and are boxcar-averaged over
// N = 2**AVG_LOG2 samples. A target level soft-starts toward the commanded setpoint
// (RAMP), then follows it directly (TRACK). The signed 17-bit error word
// target - average feeds the PID controller. A run of FAULT_COUNT consecutive
// over-limit errors in TRACK latches FAULT, which forces the error to zero until the
// channel is disabled.
//
// Optional build macro: PID_ERR_DEADBAND_EN zeroes the registered error whenever
// |error| <= DEADBAND (err_valid and fault counting are unaffected).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                channel enable (level)
//   setpoint[15:0]        unsigned commanded level, sampled on each accept
//   meas_valid/meas_data  feedback sample handshake, 16-bit unsigned data
//   meas_ready            high in RAMP and TRACK
//   error[16:0]           signed target - average, held between updates
//   err_valid             one-cycle pulse when error updates
//   target[15:0]          current ramped target
//   state[1:0]            IDLE=0, RAMP=1, TRACK=2, FAULT=3
//   fault                 high in FAULT
module pid_error_gen #(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned RAMP_STEP   = 64,
  parameter int unsigned FAULT_LIMIT = 4096,
  parameter int unsigned FAULT_COUNT = 3,
  parameter int unsigned DEADBAND    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] setpoint,
  input  logic        meas_valid,
  input  logic [15:0] meas_data,
  output logic        meas_ready,
  output logic [16:0] error,
  output logic        err_valid,
  output logic [15:0] target,
  output logic [1:0]  state,
  output logic        fault
);

  localparam int unsigned N  = 2 ** AVG_LOG2;
  localparam int unsigned SW = 16 + AVG_LOG2;

  localparam logic [16:0] Step17   = 17'(RAMP_STEP);
  localparam logic [15:0] Step16   = 16'(RAMP_STEP);
  localparam logic [16:0] FaultLim = 17'(FAULT_LIMIT);
  localparam logic [16:0] DbLim    = 17'(DEADBAND);

`ifdef PID_ERR_DEADBAND_EN
  localparam bit DbEn = 1'b1;
`else
  localparam bit DbEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRamp  = 2'd1,
    StTrack = 2'd2,
    StFault = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         target_q, target_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [15:0]         smp_q [N];
  logic                smp_wr, smp_clr;
  logic                s1_q, s1_d;
  logic [16:0]         error_q, error_d;
  logic                ev_q, ev_d;

  logic                accept;
  logic [SW-1:0]       sum_acc;
  logic [15:0]         avg_acc, avg_q;
  logic [16:0]         err_trk, err_raw;
  logic                over;
  logic [7:0]          cnt_inc;
  logic [16:0]         ramp_diff;
  logic [15:0]         ramp_tgt;
  logic                in_band;

  function automatic logic [16:0] abs17(input logic [16:0] v);
    return v[16] ? (~v + 17'd1) : v;
  endfunction

  assign meas_ready = (state_q == StRamp) || (state_q == StTrack);
  assign accept     = meas_valid && meas_ready;

  // The oldest entry is always part of sum_q, so the subtraction never underflows.
  assign sum_acc = sum_q - SW'(smp_q[ptr_q]) + SW'(meas_data);
  assign avg_acc = 16'(sum_acc >> AVG_LOG2);
  assign avg_q   = 16'(sum_q >> AVG_LOG2);

  // Error the TRACK sample will produce, needed on edge 1 so the fault trips there.
  assign err_trk = {1'b0, setpoint} - {1'b0, avg_acc};
  assign over    = abs17(err_trk) > FaultLim;
  assign cnt_inc = cnt_q + 8'd1;

  // Error of the sample registered on the previous edge (stage 2 input).
  assign err_raw = {1'b0, target_q} - {1'b0, avg_q};
  assign in_band = DbEn && (abs17(err_raw) <= DbLim);

  // Move target one step toward setpoint, never overshooting it.
  always_comb begin
    ramp_diff = {1'b0, setpoint} - {1'b0, target_q};
    ramp_tgt  = setpoint;
    if (ramp_diff[16]) begin
      if ((~ramp_diff + 17'd1) > Step17) ramp_tgt = target_q - Step16;
    end else if (ramp_diff > Step17) begin
      ramp_tgt = target_q + Step16;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    ptr_d    = ptr_q;
    smp_wr   = 1'b0;
    smp_clr  = 1'b0;
    s1_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        target_d = '0;
        cnt_d    = '0;
        if (enable) begin
          state_d = StRamp;
          sum_d   = '0;
          ptr_d   = '0;
          smp_clr = 1'b1;
        end
      end
      StRamp: begin
        if (!enable) begin
          state_d  = StIdle;
          target_d = '0;
        end else if (accept) begin
          smp_wr   = 1'b1;
          sum_d    = sum_acc;
          ptr_d    = ptr_q + 1'b1;
          target_d = ramp_tgt;
          s1_d     = 1'b1;
          if (ramp_tgt == setpoint) state_d = StTrack;
        end
      end
      StTrack: begin
        if (!enable) begin
          state_d  = StIdle;
          target_d = '0;
          cnt_d    = '0;
        end else if (accept) begin
          smp_wr   = 1'b1;
          sum_d    = sum_acc;
          ptr_d    = ptr_q + 1'b1;
          target_d = setpoint;
          s1_d     = 1'b1;
          if (!over) begin
            cnt_d = '0;
          end else if (32'(cnt_inc) >= FAULT_COUNT) begin
            state_d = StFault;
            cnt_d   = '0;
            s1_d    = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StFault: begin
        if (!enable) begin
          state_d  = StIdle;
          target_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 2: IDLE/FAULT (including a disable arriving with a sample in flight)
  // force the error to zero and suppress the pulse.
  always_comb begin
    error_d = error_q;
    ev_d    = 1'b0;
    if (state_d == StIdle || state_d == StFault) begin
      error_d = '0;
    end else if (s1_q) begin
      error_d = in_band ? 17'd0 : err_raw;
      ev_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      ptr_q    <= '0;
      s1_q     <= 1'b0;
      error_q  <= '0;
      ev_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      ptr_q    <= ptr_d;
      s1_q     <= (state_d == StIdle) ? 1'b0 : s1_d;
      error_q  <= error_d;
      ev_q     <= ev_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) smp_q[i] <= '0;
    end else if (smp_clr) begin
      for (int i = 0; i < int'(N); i++) smp_q[i] <= '0;
    end else if (smp_wr) begin
      smp_q[ptr_q] <= meas_data;
    end
  end

  assign error     = error_q;
  assign err_valid = ev_q;
  assign target    = target_q;
  assign state     = state_q;
  assign fault     = (state_q == StFault);

endmodule

// File: doc/pid_error_gen.md
# pid_error_gen

Front end of the stimulation control loop. Accepts feedback samples from the measurement path over a valid/ready handshake and boxcar-averages them. Soft-starts a target level toward the commanded setpoint and produces the signed 17-bit error word consumed by the PID controller. Also watches for persistent large error and latches a fault that forces the error to zero until the channel is disabled.

## Interface
Parameters:
- `AVG_LOG2`, 2: log2 of boxcar length (1..4); buffer depth `N = 2**AVG_LOG2`.
- `RAMP_STEP`, 64: target increment/decrement per accepted sample while ramping (1..65535).
- `FAULT_LIMIT`, 4096: raw `|error|` strictly above this counts as an over-limit sample.
- `FAULT_COUNT`, 3: consecutive over-limit samples in TRACK that trip the fault (1..255).
- `DEADBAND`, 8: deadband half-width; used only when `PID_ERR_DEADBAND_EN` is defined.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: channel enable, level sensitive.
- `setpoint`, in, 16: unsigned commanded level; sampled each accepted sample.
- `meas_valid`, in, 1: feedback sample valid.
- `meas_data`, in, 16: unsigned feedback sample.
- `meas_ready`, out, 1: sample accepted when `meas_valid && meas_ready`.
- `error`, out, 17: signed `target - average`, held between updates; feeds the PID `error` input.
- `err_valid`, out, 1: one-cycle pulse when `error` updates.
- `target`, out, 16: current ramped target.
- `state`, out, 2: IDLE=0, RAMP=1, TRACK=2, FAULT=3.
- `fault`, out, 1: high in FAULT.

## Operation
- Reset values: all outputs 0, state IDLE, buffer, running sum and fault counter cleared. Reset asserted mid-operation takes effect immediately.
- `meas_ready` is 1 in RAMP and TRACK and 0 in IDLE and FAULT. Samples may arrive every cycle.
- State transitions:
  - IDLE -> RAMP when `enable=1`. Entering RAMP clears the sample buffer, running sum and `target` to 0.
  - RAMP: each accepted sample moves `target` toward `setpoint` by `RAMP_STEP`, clamped so it never passes `setpoint`. Direction follows `setpoint`, which may change mid-ramp. When the updated target equals `setpoint`, go to TRACK on the same edge. If `setpoint=0` on entry, the first sample moves to TRACK.
  - TRACK: each accepted sample sets `target = setpoint` with no ramping.
  - Any state except FAULT -> IDLE when `enable=0`. IDLE forces `target=0` and `error=0`.
  - TRACK -> FAULT when the fault counter reaches `FAULT_COUNT`.
  - FAULT -> IDLE only when `enable=0`. In FAULT, `error` is forced to 0, `target` is held and `err_valid` stays low.
- Averaging: circular buffer of N samples with running sum (16+AVG_LOG2 bits). On each accept, `sum += new - oldest` and the oldest entry is overwritten. `avg = sum >> AVG_LOG2`, truncating. Cleared entries count as 0 until N samples have arrived.
- Error arithmetic: `{1'b0,target} - {1'b0,avg}`, exact in 17-bit signed, range -65535..+65535, with no saturation.
- Fault counter, TRACK only: increments on each computed error with raw `|error| > FAULT_LIMIT`, clears on a non-over-limit error, and clears on leaving TRACK. The counter uses the error before any deadband is applied.
- Simultaneous `enable` falling and a sample accept: the disable wins, the sample is dropped, no `err_valid` is produced, and any in-flight stage-2 result is discarded.

## Timing
- Two-stage pipeline:
  - Edge 1 after the accept: buffer, sum and target update.
  - Edge 2: `error` and `err_valid` register.
  - `err_valid` is therefore high in the second cycle after the `meas_valid && meas_ready` cycle. Back-to-back samples give back-to-back pulses.
- State changes occur on edge 1 of the accepted sample that causes them. `fault` rises together with `state=FAULT`, and `error` reads 0 from that edge onward.
- `enable` takes effect on the next edge.

## Configuration
- `PID_ERR_DEADBAND_EN`:
  - Defined: when `|error| <= DEADBAND`, the registered `error` is 0. `err_valid` still pulses and the fault counting logic is unaffected.
  - Undefined: raw error is output, and `DEADBAND` is ignored.

## Test plan
Default parameters unless stated.
- Reset: hold `rst_n=0` mid-RAMP -> all outputs 0 asynchronously and `state=0`. After release, `enable=1` re-enters RAMP with a cleared buffer.
- Ramp: `enable=1`, `setpoint=200`, `meas_data=0` every cycle -> targets 64, 128, 192, 200. Errors are +64, +128, +192, +200, each 2 cycles after its sample. `state=2` after the 4th sample.
- Averaging: `setpoint=0`, samples 400, 800, 800, 800, 800 -> errors -100, -300, -500, -700, -800. TRACK from the 1st sample, `meas_ready=1` throughout.
- Fault: in TRACK with avg 0, step `setpoint` to 10000 -> errors +10000 twice, then 3rd sample gives `fault=1`, `state=3`, `error=0`, `meas_ready=0`. `enable=0` -> IDLE with `fault=0`.
- Deadband: raw errors +5, -8, -9 -> with macro 0, 0, -9; without macro +5, -8, -9. `err_valid` pulses for all three in both builds.
- Disable collision: `enable` falls in the same cycle as an accept -> no `err_valid`, `state=0` and `error=0` on the next edge.
